// File: rtl/drum_mix_pkg.sv
// Shared constants and the 16-bit limiter for the drum mixer / I2S serializer.
// MIX_SATURATE_EN selects saturation instead of two's-complement wrap in the limiter.
package drum_mix_pkg;

    localparam int unsigned FRAME_BITS = 9;
    localparam logic [3:0] SLOT_LAST = 4'hF;
    localparam logic [FRAME_BITS-1:0] LOAD_CNT = 9'h00F;
    localparam int unsigned SUM_W = 19;
    localparam int unsigned PAN_L = 1;
    localparam int unsigned PAN_R = 0;

    typedef enum logic {
        CH_RIGHT = 1'b0,
        CH_LEFT  = 1'b1
    } chan_e;

    function automatic logic [15:0] limit16(input logic signed [SUM_W-1:0] v);
`ifdef MIX_SATURATE_EN
        if (v > 19'sd32767)
            return 16'h7FFF;
        else if (v < -19'sd32768)
            return 16'h8000;
        else
            return v[15:0];
`else
        return v[15:0];
`endif
    endfunction

endpackage

// File: rtl/drum_mix_channel.sv
// One output channel: stage 1 pan-masked voice sum, stage 2 volume shift and limit.
// Limiter behaviour follows MIX_SATURATE_EN (see drum_mix_pkg).
module drum_mix_channel
    import drum_mix_pkg::*;
#(
    parameter int unsigned NUM_VOICES = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [16*NUM_VOICES-1:0] voice_audio,
    input  logic [2*NUM_VOICES-1:0] voice_pan,
    input  logic [2:0]              volume,
    input  chan_e                   pan_sel,
    output logic [15:0]             mix
);

    logic signed [SUM_W-1:0] sum_d;
    logic signed [SUM_W-1:0] sum_q;
    logic signed [SUM_W-1:0] shifted;
    logic [2:0]              vol_q;
    logic [15:0]             sample;
    int unsigned             pan_idx;

    always_comb begin
        sum_d   = '0;
        sample  = '0;
        pan_idx = 0;
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            sample  = voice_audio[16*i +: 16];
            pan_idx = 2*i + ((pan_sel == CH_LEFT) ? PAN_L : PAN_R);
            if (voice_pan[pan_idx])
                sum_d = sum_d + {{(SUM_W-16){sample[15]}}, sample};
        end
    end

    // Volume travels with the sum so both reach stage 2 with the same latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q <= '0;
            vol_q <= '0;
        end else begin
            sum_q <= sum_d;
            vol_q <= volume;
        end
    end

    always_comb begin
        shifted = sum_q >>> (3'd7 - vol_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            mix <= '0;
        else if (vol_q == '0)
            mix <= '0;
        else
            mix <= limit16(shifted);
    end

endmodule

// File: rtl/drum_mix_i2s.sv
// Drum machine output stage: stereo voice mix plus I2S serializer for the Pmod DAC.
// Build option MIX_SATURATE_EN enables output saturation in the channel limiters.
module drum_mix_i2s
    import drum_mix_pkg::*;
#(
    parameter int unsigned NUM_VOICES = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [16*NUM_VOICES-1:0] voice_audio,
    input  logic [2*NUM_VOICES-1:0]  voice_pan,
    input  logic [2:0]               volume,
    output logic                     mclk,
    output logic                     lrck,
    output logic                     sck,
    output logic                     sdin,
    output logic                     frame_tick
);

    logic [FRAME_BITS-1:0] cnt;
    logic [31:0]           sr;
    logic [15:0]           left_mix;
    logic [15:0]           right_mix;

    drum_mix_channel #(.NUM_VOICES(NUM_VOICES)) u_left (
        .clk         (clk),
        .reset       (reset),
        .voice_audio (voice_audio),
        .voice_pan   (voice_pan),
        .volume      (volume),
        .pan_sel     (CH_LEFT),
        .mix         (left_mix)
    );

    drum_mix_channel #(.NUM_VOICES(NUM_VOICES)) u_right (
        .clk         (clk),
        .reset       (reset),
        .voice_audio (voice_audio),
        .voice_pan   (voice_pan),
        .volume      (volume),
        .pan_sel     (CH_RIGHT),
        .mix         (right_mix)
    );

    // Loading at the end of slot 0 gives the I2S one-bit delay after each lrck edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            sr         <= '0;
            frame_tick <= 1'b0;
        end else begin
            cnt        <= cnt + 1'b1;
            frame_tick <= (cnt == LOAD_CNT);
            if (cnt == LOAD_CNT)
                sr <= {left_mix, right_mix};
            else if (cnt[3:0] == SLOT_LAST)
                sr <= {sr[30:0], 1'b0};
        end
    end

    assign mclk = cnt[1];
    assign sck  = cnt[3];
    assign lrck = cnt[8];
    assign sdin = sr[31];

endmodule

// File: tb/tb_drum_mix_i2s.sv
// Self-checking bench for drum_mix_i2s: vector table, random mixes against an
// integer reference model, latency edge, and mid-frame reset sequences.
module tb_drum_mix_i2s;

    localparam int unsigned NV = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [16*NV-1:0] voice_audio = '0;
    logic [2*NV-1:0] voice_pan = '0;
    logic [2:0]      volume = '0;
    logic            mclk, lrck, sck, sdin, frame_tick;

    int checks = 0;
    int errors = 0;

    // Bench-side frame position, independent of the DUT's counter.
    logic [8:0] tb_cnt;

    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) tb_cnt <= '0;
        else       tb_cnt <= tb_cnt + 9'd1;
    end

    drum_mix_i2s #(.NUM_VOICES(NV)) dut (
        .clk         (clk),
        .reset       (reset),
        .voice_audio (voice_audio),
        .voice_pan   (voice_pan),
        .volume      (volume),
        .mclk        (mclk),
        .lrck        (lrck),
        .sck         (sck),
        .sdin        (sdin),
        .frame_tick  (frame_tick)
    );

    typedef struct packed {
        logic [63:0] audio;
        logic [7:0]  pan;
        logic [2:0]  vol;
        logic [15:0] exp_l;
        logic [15:0] exp_r;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Stereo word as the DAC would see it: floor(sum / 2^(7-vol)), then 16-bit limit.
    function automatic logic [15:0] model(input logic [63:0] a, input logic [7:0] p,
                                          input logic [2:0] vol, input bit left);
        int s;
        int d;
        int r;
        logic [15:0] smp;
        s = 0;
        for (int i = 0; i < int'(NV); i++) begin
            smp = a[16*i +: 16];
            if (p[2*i + (left ? 1 : 0)]) s += int'($signed(smp));
        end
        if (vol == 3'd0) return 16'h0000;
        d = 1 << (7 - int'(vol));
        r = (s >= 0) ? s / d : -((-s + d - 1) / d);
`ifdef MIX_SATURATE_EN
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
`endif
        return r[15:0];
    endfunction

    task automatic wait_cnt(input logic [8:0] c);
        for (int n = 0; n < 1100; n++) begin
            @(posedge clk);
            #1;
            if (tb_cnt == c) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_cnt timeout: got %h expected %h", tb_cnt, c);
    endtask

    // Decode one frame: slots 1..31 of this frame plus slot 0 of the next.
    task automatic get_frame(output logic [15:0] l, output logic [15:0] r);
        logic [31:0] w;
        w = '0;
        wait_cnt(9'h018);
        @(negedge clk);
        for (int b = 0; b < 32; b++) begin
            if (b != 0) repeat (16) @(negedge clk);
            w = {w[30:0], sdin};
        end
        l = w[31:16];
        r = w[15:0];
    endtask

    task automatic run_vec(input string name, input logic [63:0] a, input logic [7:0] p,
                           input logic [2:0] vol, input logic [15:0] el, input logic [15:0] er);
        logic [15:0] l, r;
        wait_cnt(9'h100);
        voice_audio = a;
        voice_pan   = p;
        volume      = vol;
        get_frame(l, r);
        check({name, " left"}, {16'h0, l}, {16'h0, el});
        check({name, " right"}, {16'h0, r}, {16'h0, er});
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad_mclk, bad_sck, bad_lrck, bad_tick, pulses, first_pos;
        logic [15:0] l, r;
        logic [63:0] ra;
        logic [7:0]  rp;
        logic [2:0]  rv;

        vecs[0] = '{64'h0000_0000_0000_1234, 8'b00_00_00_10, 3'd7, 16'h1234, 16'h0000};
`ifdef MIX_SATURATE_EN
        vecs[1] = '{64'h7000_7000_7000_7000, 8'b11_11_11_11, 3'd7, 16'h7FFF, 16'h7FFF};
`else
        vecs[1] = '{64'h7000_7000_7000_7000, 8'b11_11_11_11, 3'd7, 16'hC000, 16'hC000};
`endif
        vecs[2] = '{64'h0000_0000_0000_8000, 8'b00_00_00_11, 3'd5, 16'hE000, 16'hE000};
        vecs[3] = '{64'h0000_0000_0000_8000, 8'b00_00_00_11, 3'd0, 16'h0000, 16'h0000};
        vecs[4] = '{64'h0000_0005_ABCD_0000, 8'b00_10_01_00, 3'd7, 16'h0005, 16'hABCD};
        vecs[5] = '{64'hFFFF_0001_0000_0000, 8'b11_11_00_00, 3'd6, 16'h0000, 16'h0000};

        // Reset held: outputs must stay low while clk runs.
        repeat (4) @(negedge clk);
        check("reset mclk", {31'h0, mclk}, 32'h0);
        check("reset lrck", {31'h0, lrck}, 32'h0);
        check("reset sck", {31'h0, sck}, 32'h0);
        check("reset sdin", {31'h0, sdin}, 32'h0);
        check("reset frame_tick", {31'h0, frame_tick}, 32'h0);
        reset = 1'b0;

        // Clock dividers and tick position over two frames.
        bad_mclk = 0; bad_sck = 0; bad_lrck = 0; bad_tick = 0;
        for (int i = 0; i < 1024; i++) begin
            @(negedge clk);
            if (mclk !== tb_cnt[1]) bad_mclk++;
            if (sck !== tb_cnt[3]) bad_sck++;
            if (lrck !== tb_cnt[8]) bad_lrck++;
            if (frame_tick !== (tb_cnt == 9'h010)) bad_tick++;
        end
        check("mclk clk/4 bad cycles", bad_mclk, 0);
        check("sck clk/16 bad cycles", bad_sck, 0);
        check("lrck clk/512 bad cycles", bad_lrck, 0);
        check("frame_tick position bad cycles", bad_tick, 0);

        for (int i = 0; i < 6; i++)
            run_vec($sformatf("vec%0d", i), vecs[i].audio, vecs[i].pan, vecs[i].vol,
                    vecs[i].exp_l, vecs[i].exp_r);

        for (int i = 0; i < 8; i++) begin
            ra = {$urandom, $urandom};
            rp = 8'($urandom);
            rv = 3'($urandom_range(0, 7));
            run_vec($sformatf("rand%0d", i), ra, rp, rv, model(ra, rp, rv, 1'b1),
                    model(ra, rp, rv, 1'b0));
        end

        // A change just after the edge that ends cnt==X is "a change at cnt==X".
        voice_audio = 64'h0000_0000_0000_0100;
        voice_pan   = 8'b00_00_00_11;
        volume      = 3'd7;
        wait_cnt(9'h100);
        wait_cnt(9'h00D);
        voice_audio = 64'h0000_0000_0000_0200;
        get_frame(l, r);
        check("latency change at 00C", {16'h0, l}, 32'h0200);

        voice_audio = 64'h0000_0000_0000_0100;
        wait_cnt(9'h100);
        wait_cnt(9'h00E);
        voice_audio = 64'h0000_0000_0000_0200;
        get_frame(l, r);
        check("latency change at 00D", {16'h0, l}, 32'h0100);

        // Mid-frame reset while sdin and lrck are both high.
        voice_audio = 64'h0000_0000_0000_FFFF;
        wait_cnt(9'h100);
        wait_cnt(9'h010);
        wait_cnt(9'h148);
        @(negedge clk);
        check("slot20 sdin before reset", {31'h0, sdin}, 32'h1);
        check("slot20 lrck before reset", {31'h0, lrck}, 32'h1);
        #2 reset = 1'b1;
        #1;
        check("async reset sdin", {31'h0, sdin}, 32'h0);
        check("async reset lrck", {31'h0, lrck}, 32'h0);
        check("async reset sck", {31'h0, sck}, 32'h0);
        check("async reset mclk", {31'h0, mclk}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        pulses = 0;
        first_pos = -1;
        for (int i = 0; i < 1536; i++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) begin
                if (first_pos < 0) first_pos = int'(tb_cnt) + 512 * (i / 512);
                pulses++;
            end
        end
        check("post-reset tick count", pulses, 3);
        check("post-reset first tick cnt", first_pos, 32'h010);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/drum_mix_i2s.md
# drum_mix_i2s

Downstream audio stage of the drum machine. Collects the 16-bit sample streams from all drum-voice track iterators (snare, kick, hi-hat, …). Sums each stage into left and right using per-voice pan masks, applies master volume, and limits the result to 16 bits. Serializes the stereo frame to the Pmod I2S DAC on the system clock domain.

## Interface
Parameters:
- NUM_VOICES, 4, number of voice inputs (1–8)

Ports:
- clk  in  1  system clock, 100 MHz
- reset  in  1  reset, asynchronous, active-high
- voice_audio  in  16*NUM_VOICES  voice i sample at [16i+15:16i], two's complement
- voice_pan  in  2*NUM_VOICES  voice i {left_en,right_en} at [2i+1:2i]
- volume  in  3  master volume, 0 = mute, 7 = full
- mclk  out  1  DAC master clock, clk/4
- lrck  out  1  word select, clk/512; 0 = left, 1 = right
- sck  out  1  serial bit clock, clk/16
- sdin  out  1  serial data, I2S format, MSB first
- frame_tick  out  1  one-clk pulse when a new stereo frame is loaded

## Operation
- Free-running 9-bit frame counter cnt increments every clk and wraps 511→0.
  - mclk = cnt[1], sck = cnt[3], lrck = cnt[8].
  - Slot index k = cnt[8:4] (32 slots per frame, 16 per channel).
- Mix, per channel, independently:
  - Sign-extend each voice sample to 19 bits.
  - Add the voice to the left sum when pan bit 1 is set; add it to the right sum when pan bit 0 is set.
  - Volume: 0 forces 0. Otherwise the sum is arithmetically shifted right by (7 − volume); volume 7 means no shift.
  - Result limited to 16 bits per the Configuration section.
- Serializer: 32-bit shift register sr, with sdin driven by sr[31].
  - At the last clk of slot 0 (cnt == 9'h00F), sr loads {left_mix, right_mix}.
  - At the last clk of every other slot (cnt[3:0] == 4'hF, k ≠ 0), sr shifts left by 1 with zero fill.
  - Result: slot 1 carries left bit 15, slot 16 carries left bit 0, slot 17 carries right bit 15, and slot 0 of the next frame carries right bit 0. This is the standard I2S one-bit delay after each lrck edge.
- frame_tick is asserted in the clk immediately after the sr load.
- Voice inputs are asynchronous to frame timing. The value captured is whatever the mix pipeline holds at cnt == 9'h00F.

## Timing
- Mix pipeline has 2 registered stages:
  - Stage 1: per-channel pan-masked sum.
  - Stage 2: volume shift and limit.
- Input-to-mix latency is 2 clk. A change on any input appears in left_mix/right_mix 2 clk later.
- sr load samples the stage-2 output at cnt == 9'h00F. Its first bit appears on sdin in slot 1.
- sdin changes only on clk edges where cnt[3:0] wraps to 0. This is the sck falling edge, giving a half-sck setup and hold to the DAC.
- Reset values: cnt = 0, sr = 0, both pipeline stages = 0. Therefore mclk = lrck = sck = sdin = 0 and frame_tick = 0.
- Reset mid-frame: all outputs go to 0 immediately (asynchronous). After release, the first load occurs at cnt == 9'h00F.
- Volume or pan change mid-frame: no effect on the frame being shifted. The change takes effect at the next load.

## Configuration
- MIX_SATURATE_EN defined:
  - Stage-2 result saturates to 16'h7FFF when it is above +32767.
  - It saturates to 16'h8000 when it is below −32768.
- MIX_SATURATE_EN undefined: the stage-2 result is the low 16 bits of the shifted sum (two's-complement wrap). This saves the comparators.

## Structure
- Package drum_mix_pkg holds:
  - FRAME_BITS = 9, SLOT_LAST = 4'hF, LOAD_CNT = 9'h00F.
  - SUM_W = 19.
  - The pan bit positions PAN_L = 1 and PAN_R = 0.
- Sub-module drum_mix_channel contains one channel's stage-1 sum, stage-2 volume shift and limiter.
  - It takes a NUM_VOICES parameter and a 1-bit pan-select input.
  - The top level instantiates it twice (left, right).
  - The frame counter and serializer live in the top level.

## Test plan
- Reset held, then released → mclk, lrck, sck, sdin, frame_tick all 0 while reset is held. Frequencies after release: mclk = 25 MHz, sck = 6.25 MHz, lrck = 195.3125 kHz.
- Voice0 = 16'h1234, pan = 2'b10, other voices 0, volume 7 → left word 16'h1234 and right word 16'h0000. Decoded from sdin, left bit 15 appears in slot 1 and right bit 0 appears in slot 0 of the next frame.
- All 4 voices = 16'h7000, pan = 2'b11, volume 7, MIX_SATURATE_EN defined → both words 16'h7FFF. With the macro undefined → both words 16'hC000.
- Voice0 = 16'h8000, pan 2'b11, volume 5 → both words 16'hE000 (shift right by 2, sign preserved). Volume 0 → both words 16'h0000.
- Voice0 changes from 16'h0100 to 16'h0200 at cnt == 9'h00D → 16'h0200 is not in the current frame (2-clk latency). A change at cnt == 9'h00C → 16'h0200 is in the current frame.
- Reset asserted at slot 20 → sdin and lrck drop to 0 asynchronously. After release, frame_tick pulses exactly once per 512 clk, first at cnt == 9'h010.
